// File: rtl/spi_pkg.sv
//==============================================================================
// Module : spi_pkg
// Brief  : Shared state encoding, byte width and counter sizing helpers for
//          the SPI master.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package spi_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CS_SETUP = 3'd1,
      ST_BIT_LOW  = 3'd2,
      ST_BIT_HIGH = 3'd3,
      ST_CS_HOLD  = 3'd4,
      ST_HELD     = 3'd5
   } spi_master_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int cnt_width(input int a, input int b, input int c);
      return $clog2(max3(a, b, c)) + 1;
   endfunction

   // Wire order of bit number idx within the byte.
   function automatic logic [2:0] bit_pos(input logic [2:0] idx, input logic msb_first);
      return msb_first ? (3'd7 - idx) : idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_divider.sv
//==============================================================================
// Module : spi_clk_divider
// Brief  : Reloadable down-counter; o_tick is high in the last clock of each
//          loaded phase (reload value N-1 gives an N-clock phase).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_clk_divider #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_reload,
   input  logic [CNT_W-1:0] i_reload_val,
   output logic             o_tick
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_reload) begin
         r_cnt <= i_reload_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tick = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
//==============================================================================
// Module : spi_master
// Brief  : Byte-wide mode-0 SPI master with start/done handshake and optional
//          cs_n hold across bytes. Define SPI_MASTER_MSB_FIRST_EN for MSB-first.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV      = 4,
   parameter int CS_SETUP_CYC = 2,
   parameter int CS_HOLD_CYC  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SPI_BYTE_W-1:0] tx_byte,
   input  logic                  hold_cs,
   input  logic                  miso,
   output logic                  spi_clk,
   output logic                  mosi,
   output logic                  cs_n,
   output logic                  busy,
   output logic                  done,
   output logic [SPI_BYTE_W-1:0] rx_byte
);

   localparam int CNT_W = cnt_width(CLK_DIV, CS_SETUP_CYC, CS_HOLD_CYC);
   localparam logic [CNT_W-1:0] C_DIV_LOAD   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] C_SETUP_LOAD = CNT_W'(CS_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] C_HOLD_LOAD  = CNT_W'(CS_HOLD_CYC - 1);

`ifdef SPI_MASTER_MSB_FIRST_EN
   localparam logic C_MSB_FIRST = 1'b1;
`else
   localparam logic C_MSB_FIRST = 1'b0;
`endif

   spi_master_state_t     r_state;
   logic [SPI_BYTE_W-1:0] r_tx;
   logic [SPI_BYTE_W-1:0] r_rx;
   logic [2:0]            r_idx;
   logic                  r_from_held;

   logic                  w_tick;
   logic                  w_reload;
   logic [CNT_W-1:0]      w_reload_val;
   logic [2:0]            w_cur_pos;
   logic [2:0]            w_next_pos;
   logic [2:0]            w_first_pos;
   logic [SPI_BYTE_W-1:0] w_rx_sampled;

   assign w_cur_pos   = bit_pos(r_idx, C_MSB_FIRST);
   assign w_next_pos  = bit_pos(r_idx + 3'd1, C_MSB_FIRST);
   assign w_first_pos = bit_pos(3'd0, C_MSB_FIRST);

   always_comb begin
      w_rx_sampled            = r_rx;
      w_rx_sampled[w_cur_pos] = miso;
   end

   // One counter times every phase; it is reloaded on each phase change.
   always_comb begin
      w_reload     = 1'b0;
      w_reload_val = C_DIV_LOAD;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_reload     = 1'b1;
               w_reload_val = C_SETUP_LOAD;
            end
         end
         ST_CS_SETUP, ST_BIT_LOW: begin
            w_reload = w_tick;
         end
         ST_BIT_HIGH: begin
            if (w_tick) begin
               w_reload = 1'b1;
               if (r_idx == 3'd7) begin
                  w_reload_val = C_HOLD_LOAD;
               end
            end
         end
         ST_HELD: begin
            if (start) begin
               w_reload = 1'b1;
            end else if (!hold_cs) begin
               w_reload     = 1'b1;
               w_reload_val = C_HOLD_LOAD;
            end
         end
         default: begin
         end
      endcase
   end

   spi_clk_divider #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk          (clk),
      .rst          (rst),
      .i_reload     (w_reload),
      .i_reload_val (w_reload_val),
      .o_tick       (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_tx        <= '0;
         r_rx        <= '0;
         r_idx       <= 3'd0;
         r_from_held <= 1'b0;
         spi_clk     <= 1'b0;
         mosi        <= 1'b0;
         cs_n        <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         rx_byte     <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_tx        <= tx_byte;
                  r_from_held <= 1'b0;
                  cs_n        <= 1'b0;
                  busy        <= 1'b1;
                  r_state     <= ST_CS_SETUP;
               end
            end
            ST_CS_SETUP: begin
               if (w_tick) begin
                  r_idx   <= 3'd0;
                  mosi    <= r_tx[w_first_pos];
                  r_state <= ST_BIT_LOW;
               end
            end
            ST_BIT_LOW: begin
               if (w_tick) begin
                  spi_clk <= 1'b1;
                  r_state <= ST_BIT_HIGH;
               end
            end
            ST_BIT_HIGH: begin
               if (w_tick) begin
                  spi_clk <= 1'b0;
                  r_rx    <= w_rx_sampled;
                  if (r_idx == 3'd7) begin
                     if (hold_cs) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_byte <= w_rx_sampled;
                        r_state <= ST_HELD;
                     end else begin
                        r_state <= ST_CS_HOLD;
                     end
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     mosi    <= r_tx[w_next_pos];
                     r_state <= ST_BIT_LOW;
                  end
               end
            end
            ST_CS_HOLD: begin
               if (w_tick) begin
                  cs_n    <= 1'b1;
                  busy    <= 1'b0;
                  mosi    <= 1'b0;
                  r_state <= ST_IDLE;
                  // A byte that already reported from HELD must not report twice.
                  if (!r_from_held) begin
                     done    <= 1'b1;
                     rx_byte <= r_rx;
                  end
               end
            end
            ST_HELD: begin
               if (start) begin
                  r_tx        <= tx_byte;
                  r_idx       <= 3'd0;
                  r_from_held <= 1'b0;
                  mosi        <= tx_byte[w_first_pos];
                  busy        <= 1'b1;
                  r_state     <= ST_BIT_LOW;
               end else if (!hold_cs) begin
                  r_from_held <= 1'b1;
                  busy        <= 1'b1;
                  r_state     <= ST_CS_HOLD;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
//==============================================================================
// Module : tb_spi_master
// Brief  : Scoreboard bench for spi_master with a behavioural SPI slave model.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_master;

   localparam int DIV   = 4;
   localparam int SETUP = 2;
   localparam int HOLD  = 2;

   logic       clk     = 1'b0;
   logic       rst     = 1'b1;
   logic       start   = 1'b0;
   logic       hold_cs = 1'b0;
   logic       miso    = 1'b0;
   logic [7:0] tx_byte = 8'h00;
   logic       spi_clk;
   logic       mosi;
   logic       cs_n;
   logic       busy;
   logic       done;
   logic [7:0] rx_byte;

   spi_master #(
      .CLK_DIV      (DIV),
      .CS_SETUP_CYC (SETUP),
      .CS_HOLD_CYC  (HOLD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .tx_byte (tx_byte),
      .hold_cs (hold_cs),
      .miso    (miso),
      .spi_clk (spi_clk),
      .mosi    (mosi),
      .cs_n    (cs_n),
      .busy    (busy),
      .done    (done),
      .rx_byte (rx_byte)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  tx;
      logic [7:0]  rx;
      int unsigned t0;
      int unsigned lat;
      logic        hold;
   } exp_t;

   exp_t        sb_q[$];
   logic [7:0]  slave_q[$];
   logic [7:0]  wire_q[$];
   exp_t        e;
   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;
   int          sb_cnt = 0;
   int          wcnt   = 0;
   int          edges  = 0;
   logic [7:0]  wire_byte = 8'h00;
   logic [7:0]  sb_cur;
   logic        mosi_rise = 1'b0;

   function automatic int bpos(input int k);
`ifdef SPI_MASTER_MSB_FIRST_EN
      return 7 - k;
`else
      return k;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Slave: presents its byte in wire order, shifting on each falling spi_clk.
   always @(negedge clk) begin
      if (slave_q.size() != 0) begin
         sb_cur = slave_q[0];
         miso   = sb_cur[bpos(sb_cnt)];
      end else begin
         miso = 1'b0;
      end
   end

   always @(negedge spi_clk) begin
      if (!rst) begin
         sb_cnt++;
         if (sb_cnt == 8) begin
            sb_cnt = 0;
            if (slave_q.size() != 0) void'(slave_q.pop_front());
         end
      end
   end

   always @(posedge spi_clk) begin
      mosi_rise             = mosi;
      wire_byte[bpos(wcnt)] = mosi;
      wcnt++;
      edges++;
      if (wcnt == 8) begin
         wire_q.push_back(wire_byte);
         wcnt = 0;
      end
   end

   // Monitor: wire-level invariants plus scoreboard pop on every done pulse.
   always @(negedge clk) begin
      if (!rst && spi_clk) begin
         chk("mosi_stable_high", 32'(mosi), 32'(mosi_rise));
         chk("cs_n_low_while_clocking", 32'(cs_n), 32'd0);
      end
      if (!rst && done) begin
         if (sb_q.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("rx_byte", 32'(rx_byte), 32'(e.rx));
            chk("done_latency", cyc - e.t0, e.lat);
            chk("cs_n_at_done", 32'(cs_n), 32'(!e.hold));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("sclk_rises", 32'(edges), 32'd8);
            chk("mosi_byte_count", 32'(wire_q.size()), 32'd1);
            if (wire_q.size() != 0) chk("mosi_byte", 32'(wire_q.pop_front()), 32'(e.tx));
         end
         edges = 0;
      end
   end

   task automatic issue(input logic [7:0] tx, input logic [7:0] slv,
                        input logic hold, input logic from_held);
      exp_t x;
      @(posedge clk); #1;
      x.tx   = tx;
      x.rx   = slv;
      x.hold = hold;
      x.t0   = cyc;
      x.lat  = (from_held ? 0 : SETUP) + 16 * DIV + (hold ? 0 : HOLD) + 1;
      sb_q.push_back(x);
      slave_q.push_back(slv);
      start   = 1'b1;
      tx_byte = tx;
      hold_cs = hold;
      @(posedge clk); #1;
      start   = 1'b0;
      tx_byte = 8'($urandom);
      @(negedge clk);
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("cs_n_after_start", 32'(cs_n), 32'd0);
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("done_seen", 32'(seen), 32'd1);
   endtask

   task automatic send(input logic [7:0] tx, input logic [7:0] slv,
                       input logic hold, input logic from_held);
      issue(tx, slv, hold, from_held);
      wait_done();
   endtask

   // Drop hold_cs in HELD: cs_n must rise HOLD clocks later with no done.
   task automatic release_cs();
      @(posedge clk); #1;
      hold_cs = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= HOLD + 1; k++) begin
         @(negedge clk);
         chk("release_cs_n", 32'(cs_n), 32'(k == HOLD + 1));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic rel;
      logic [7:0] b;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_cs_n", 32'(cs_n), 32'd1);
         chk("idle_spi_clk", 32'(spi_clk), 32'd0);
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_done", 32'(done), 32'd0);
         chk("idle_rx_byte", 32'(rx_byte), 32'd0);
      end

      // Single byte, slave echoes the same pattern.
      send(8'hA5, 8'hA5, 1'b0, 1'b0);
      chk("mosi_idle_after_byte", 32'(mosi), 32'd0);
      send(8'h80, 8'h80, 1'b0, 1'b0);

      // Two-byte frame with cs_n held between bytes.
      send(8'h12, 8'h6C, 1'b1, 1'b0);
      @(negedge clk);
      chk("held_cs_n", 32'(cs_n), 32'd0);
      chk("held_busy", 32'(busy), 32'd0);
      send(8'h34, 8'hE1, 1'b0, 1'b1);

      // A second start mid-transfer is ignored.
      issue(8'h3C, 8'h5B, 1'b0, 1'b0);
      repeat (9) @(posedge clk);
      #1 start = 1'b1;
      tx_byte  = 8'hFF;
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      repeat (100) @(negedge clk);
      chk("idle_after_ignored_start", 32'(busy), 32'd0);

      // Asynchronous reset during bit 3 aborts the byte.
      issue(8'hC7, 8'h29, 1'b0, 1'b0);
      for (int i = 0; i < 200 && edges < 3; i++) @(negedge clk);
      for (int i = 0; i < 50 && spi_clk; i++) @(negedge clk);
      chk("abort_at_bit3", 32'(edges), 32'd3);
      rst = 1'b1;
      #1;
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_spi_clk", 32'(spi_clk), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rx_byte", 32'(rx_byte), 32'd0);
      sb_q.delete();
      slave_q.delete();
      wire_q.delete();
      sb_cnt = 0;
      wcnt   = 0;
      edges  = 0;
      @(posedge clk); #1 rst = 1'b0;
      send(8'h5A, 8'h96, 1'b0, 1'b0);

      // Held byte closed by dropping hold_cs without a further start.
      send(8'hF0, 8'h0F, 1'b1, 1'b0);
      release_cs();

      // Random frames of 1..3 bytes, closed either by the last byte or by release.
      for (int f = 0; f < 20; f++) begin
         n   = int'($urandom_range(1, 3));
         rel = 1'($urandom_range(0, 1));
         for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            send(b, 8'($urandom), (k != n - 1) || rel, k != 0);
         end
         if (rel) release_cs();
      end

      repeat (20) @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      chk("no_extra_wire_bytes", 32'(wire_q.size()), 32'd0);
      chk("final_cs_n", 32'(cs_n), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
